// File: rtl/sa_row_feeder.sv
// Left-edge feeder for a weight-stationary systolic array: buffers a weight tile,
// bursts it in, streams diagonally skewed activations, then drains with zeros.
// Optional stall counter port enabled by defining SA_FEEDER_STALL_CNT_EN.
module sa_row_feeder #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 4,
    parameter int COLS      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      cfg_out_model,
    input  logic                      cfg_sx,
    input  logic                      cfg_sy,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [ROWS*BIT_WIDTH-1:0] w_data,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [ROWS*BIT_WIDTH-1:0] a_data,
    input  logic                      a_last,
    output logic                      load_weight,
    output logic                      out_model,
    output logic                      Sx,
    output logic                      Sy,
    output logic [ROWS*BIT_WIDTH-1:0] sa_left,
    output logic                      busy,
    output logic                      done
`ifdef SA_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int DW           = ROWS * BIT_WIDTH;
    localparam int DRAIN_CYCLES = ROWS + COLS - 1;
    localparam int CNT_MAX      = (COLS > ROWS + COLS) ? COLS : ROWS + COLS;
    localparam int CW           = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        SHIFT,
        STREAM,
        DRAIN
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [DW-1:0]   wbuf_reg [COLS];
    logic            start_acc;
    logic            w_fire;
    logic            a_fire;
    logic [DW-1:0]   shift_word;
    logic [DW-1:0]   sa_left_next;
    logic            done_next;
    logic [DW-1:0]   skew_in;
    logic [DW-1:0]   skew_out;

    // w_ready/a_ready registers mirror COLLECT/STREAM, so they gate the handshakes
    assign w_fire  = w_valid & w_ready;
    assign a_fire  = a_valid & a_ready;
    assign skew_in = a_fire ? a_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        start_acc    = 1'b0;
        shift_word   = '0;
        sa_left_next = '0;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_next = COLLECT;
                    cnt_next   = '0;
                end
            end
            COLLECT: begin
                if (w_fire) begin
                    if (cnt_reg == CW'(COLS - 1)) begin
                        state_next = SHIFT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            SHIFT: begin
                if (cnt_reg == CW'(COLS - 1)) begin
                    state_next = STREAM;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            STREAM: begin
                if (a_fire && a_last) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end
            end
            DRAIN: begin
                if (cnt_reg == CW'(DRAIN_CYCLES - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // Beat shown during the upcoming SHIFT cycle; a single-beat tile bypasses the buffer
        if (state_reg == COLLECT) begin
            shift_word = (COLS == 1) ? w_data : wbuf_reg[0];
        end else begin
            for (int k = 0; k < COLS; k++) begin
                if (cnt_next == CW'(k)) begin
                    shift_word = wbuf_reg[k];
                end
            end
        end

        if (state_next == SHIFT) begin
            sa_left_next = shift_word;
        end else if (state_next == STREAM || state_next == DRAIN) begin
            sa_left_next = skew_out;
        end

        done_next = (state_next == DRAIN) && (cnt_next == CW'(DRAIN_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ready     <= 1'b0;
            a_ready     <= 1'b0;
            load_weight <= 1'b0;
            out_model   <= 1'b0;
            Sx          <= 1'b0;
            Sy          <= 1'b0;
            sa_left     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            for (int k = 0; k < COLS; k++) begin
                wbuf_reg[k] <= '0;
            end
        end else begin
            w_ready     <= (state_next == COLLECT);
            a_ready     <= (state_next == STREAM);
            load_weight <= (state_next == SHIFT);
            sa_left     <= sa_left_next;
            busy        <= (state_next != IDLE);
            done        <= done_next;
            if (start_acc) begin
                out_model <= cfg_out_model;
                Sx        <= cfg_sx;
                Sy        <= cfg_sy;
            end
            for (int k = 0; k < COLS; k++) begin
                if (w_fire && cnt_reg == CW'(k)) begin
                    wbuf_reg[k] <= w_data;
                end
            end
        end
    end

    // Row r gets r extra cycles of delay so activations enter the array diagonally
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_skew
            if (gi == 0) begin : g_row0
                assign skew_out[BIT_WIDTH-1:0] = skew_in[BIT_WIDTH-1:0];
            end else begin : g_rowd
                logic [BIT_WIDTH-1:0] chain_reg [gi];
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        for (int k = 0; k < gi; k++) begin
                            chain_reg[k] <= '0;
                        end
                    end else begin
                        chain_reg[0] <= skew_in[gi*BIT_WIDTH +: BIT_WIDTH];
                        for (int k = 1; k < gi; k++) begin
                            chain_reg[k] <= chain_reg[k-1];
                        end
                    end
                end
                assign skew_out[gi*BIT_WIDTH +: BIT_WIDTH] = chain_reg[gi-1];
            end
        end
    endgenerate

`ifdef SA_FEEDER_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if (((state_reg == COLLECT) && !w_valid) ||
                     ((state_reg == STREAM) && !a_valid)) begin
            if (stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
